// File: rtl/quad_phase_sequencer.sv
// quad_phase_sequencer
//   Sine/cosine table-index generator. Two modular counters (SIN, COS) walk a period of P+1
//   samples (0..P); COS leads SIN by a programmable offset. Period, step and offset are
//   runtime-programmable through a one-deep shadow register with a valid/ready handshake.
//   A new config is applied on a SIN wrap, or immediately while the counters are halted.
//
// Optional feature: define COUNTER_SYNC_EN to add the sync_i realign strobe.
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous reset, active-high
//   sync_i         realign strobe (COUNTER_SYNC_EN only)
//   en_i           advance enable; counters hold when low
//   cfg_valid_i    new config offered
//   cfg_ready_o    config slot free
//   cfg_period_i   new P (last index)
//   cfg_offset_i   new COS offset
//   cfg_step_i     new increment
//   cfg_err_o      1-cycle pulse: offered config rejected
//   phase_start_o  1-cycle pulse: SIN wrapped (or was realigned) at the previous edge
//   sin_counter_o  sine index
//   cos_counter_o  cosine index
module quad_phase_sequencer #(
  parameter int unsigned WIDTH            = 8,
  parameter int unsigned THRESHOLD        = 39,
  parameter int unsigned QUADRATURE_START = 10,
  parameter int unsigned STEP_DEFAULT     = 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
`ifdef COUNTER_SYNC_EN
  input  logic             sync_i,
`endif
  input  logic             en_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [WIDTH-1:0] cfg_period_i,
  input  logic [WIDTH-1:0] cfg_offset_i,
  input  logic [WIDTH-1:0] cfg_step_i,
  output logic             cfg_err_o,
  output logic             phase_start_o,
  output logic [WIDTH-1:0] sin_counter_o,
  output logic [WIDTH-1:0] cos_counter_o
);

  localparam logic [WIDTH-1:0] PeriodRst = WIDTH'(THRESHOLD);
  localparam logic [WIDTH-1:0] OffsetRst = WIDTH'(QUADRATURE_START);
  localparam logic [WIDTH-1:0] StepRst   = WIDTH'(STEP_DEFAULT);

  typedef enum logic [0:0] {StEmpty, StFull} shadow_st_e;

  shadow_st_e       st_d, st_q;
  logic [WIDTH-1:0] p_d, p_q;
  logic [WIDTH-1:0] step_d, step_q;
  logic [WIDTH-1:0] sin_d, sin_q;
  logic [WIDTH-1:0] cos_d, cos_q;
  logic [WIDTH-1:0] sh_p_d, sh_p_q;
  logic [WIDTH-1:0] sh_off_d, sh_off_q;
  logic [WIDTH-1:0] sh_step_d, sh_step_q;
  logic             ps_d, ps_q;
  logic             err_d, err_q;
  logic             sync;
`ifdef COUNTER_SYNC_EN
  // Active offset is only observable through a realign, so it exists only with sync.
  logic [WIDTH-1:0] off_d, off_q;
  assign sync = sync_i;
`else
  assign sync = 1'b0;
`endif

  logic [WIDTH:0] sin_sum;
  logic           sin_wrap;
  logic           apply;
  logic           cfg_ok;

  // Step <= P guarantees one subtraction is enough to bring the sum back into 0..P.
  function automatic logic [WIDTH-1:0] mod_add(input logic [WIDTH-1:0] cnt,
                                               input logic [WIDTH-1:0] inc,
                                               input logic [WIDTH-1:0] last);
    logic [WIDTH:0] nxt;
    nxt = {1'b0, cnt} + {1'b0, inc};
    if (nxt > {1'b0, last}) begin
      nxt = nxt - ({1'b0, last} + (WIDTH+1)'(1));
    end
    return nxt[WIDTH-1:0];
  endfunction

  assign sin_sum  = {1'b0, sin_q} + {1'b0, step_q};
  assign sin_wrap = sin_sum > {1'b0, p_q};
  assign apply    = (st_q == StFull) && (!en_i || sin_wrap || sync);
  assign cfg_ok   = (cfg_step_i != '0) && (cfg_step_i <= cfg_period_i) &&
                    (cfg_offset_i <= cfg_period_i);

  always_comb begin
    st_d      = st_q;
    p_d       = p_q;
    step_d    = step_q;
    sin_d     = sin_q;
    cos_d     = cos_q;
    sh_p_d    = sh_p_q;
    sh_off_d  = sh_off_q;
    sh_step_d = sh_step_q;
    ps_d      = (en_i && sin_wrap) || sync;
    err_d     = 1'b0;
`ifdef COUNTER_SYNC_EN
    off_d     = off_q;
`endif

    if (apply) begin
      p_d    = sh_p_q;
      step_d = sh_step_q;
      sin_d  = '0;
      cos_d  = sh_off_q;
      st_d   = StEmpty;
`ifdef COUNTER_SYNC_EN
      off_d  = sh_off_q;
    end else if (sync) begin
      sin_d = '0;
      cos_d = off_q;
`endif
    end else if (en_i) begin
      sin_d = mod_add(sin_q, step_q, p_q);
      cos_d = mod_add(cos_q, step_q, p_q);
    end

    // Transfer only possible while the shadow is empty, so it never collides with apply.
    if (cfg_valid_i && (st_q == StEmpty)) begin
      if (cfg_ok) begin
        sh_p_d    = cfg_period_i;
        sh_off_d  = cfg_offset_i;
        sh_step_d = cfg_step_i;
        st_d      = StFull;
      end else begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      st_q      <= StEmpty;
      p_q       <= PeriodRst;
      step_q    <= StepRst;
      sin_q     <= '0;
      cos_q     <= OffsetRst;
      sh_p_q    <= '0;
      sh_off_q  <= '0;
      sh_step_q <= '0;
      ps_q      <= 1'b0;
      err_q     <= 1'b0;
`ifdef COUNTER_SYNC_EN
      off_q     <= OffsetRst;
`endif
    end else begin
      st_q      <= st_d;
      p_q       <= p_d;
      step_q    <= step_d;
      sin_q     <= sin_d;
      cos_q     <= cos_d;
      sh_p_q    <= sh_p_d;
      sh_off_q  <= sh_off_d;
      sh_step_q <= sh_step_d;
      ps_q      <= ps_d;
      err_q     <= err_d;
`ifdef COUNTER_SYNC_EN
      off_q     <= off_d;
`endif
    end
  end

  assign cfg_ready_o   = (st_q == StEmpty);
  assign cfg_err_o     = err_q;
  assign phase_start_o = ps_q;
  assign sin_counter_o = sin_q;
  assign cos_counter_o = cos_q;

endmodule

// File: tb/tb_quad_phase_sequencer.sv
// Self-checking bench for quad_phase_sequencer: directed scenarios followed by random traffic,
// every cycle compared against a modular-arithmetic reference model.
module tb_quad_phase_sequencer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_i, en_i, cfg_valid_i, sync_in;
  logic [W-1:0] cfg_period_i, cfg_offset_i, cfg_step_i;
  logic         cfg_ready_o, cfg_err_o, phase_start_o;
  logic [W-1:0] sin_counter_o, cos_counter_o;

  always #5 clk = ~clk;

  quad_phase_sequencer #(
    .WIDTH           (W),
    .THRESHOLD       (39),
    .QUADRATURE_START(10),
    .STEP_DEFAULT    (1)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
`ifdef COUNTER_SYNC_EN
    .sync_i       (sync_in),
`endif
    .en_i         (en_i),
    .cfg_valid_i  (cfg_valid_i),
    .cfg_ready_o  (cfg_ready_o),
    .cfg_period_i (cfg_period_i),
    .cfg_offset_i (cfg_offset_i),
    .cfg_step_i   (cfg_step_i),
    .cfg_err_o    (cfg_err_o),
    .phase_start_o(phase_start_o),
    .sin_counter_o(sin_counter_o),
    .cos_counter_o(cos_counter_o)
  );

  int checks   = 0;
  int failures = 0;

  // Reference model state: active settings, counters, registered pulses, one-deep shadow.
  int m_p, m_off, m_step, m_sin, m_cos, m_sh_p, m_sh_off, m_sh_step;
  bit m_ps, m_err, m_full;
  bit sync_avail;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge(input bit rst, input bit en, input bit valid, input int per,
                            input int off, input int stp, input bit sync);
    int  sum;
    bit  wrap, apply, xfer, ok;
    if (rst) begin
      m_p = 39; m_off = 10; m_step = 1; m_sin = 0; m_cos = 10;
      m_ps = 0; m_err = 0; m_full = 0;
      return;
    end
    sum   = m_sin + m_step;
    wrap  = en && (sum > m_p);
    apply = m_full && (!en || wrap || sync);
    xfer  = valid && !m_full;
    ok    = (stp != 0) && (stp <= per) && (off <= per);
    m_ps  = wrap || sync;
    m_err = xfer && !ok;
    if (apply) begin
      m_p = m_sh_p; m_off = m_sh_off; m_step = m_sh_step;
      m_sin = 0; m_cos = m_sh_off; m_full = 0;
    end else if (sync) begin
      m_sin = 0; m_cos = m_off;
    end else if (en) begin
      m_sin = sum % (m_p + 1);
      m_cos = (m_cos + m_step) % (m_p + 1);
    end
    if (xfer && ok) begin
      m_sh_p = per; m_sh_off = off; m_sh_step = stp; m_full = 1;
    end
  endtask

  task automatic cycle(input bit rst, input bit en, input bit valid, input int per,
                       input int off, input int stp, input bit sync);
    rst_i        = rst;
    en_i         = en;
    cfg_valid_i  = valid;
    cfg_period_i = W'(per);
    cfg_offset_i = W'(off);
    cfg_step_i   = W'(stp);
    sync_in      = sync;
    @(posedge clk);
    model_edge(rst, en, valid, per, off, stp, sync);
    #1;
    check_eq("sin", 32'(sin_counter_o), 32'(m_sin));
    check_eq("cos", 32'(cos_counter_o), 32'(m_cos));
    check_eq("phase_start", 32'(phase_start_o), 32'(m_ps));
    check_eq("cfg_ready", 32'(cfg_ready_o), 32'(!m_full));
    check_eq("cfg_err", 32'(cfg_err_o), 32'(m_err));
  endtask

  task automatic run(input int n, input bit en);
    for (int i = 0; i < n; i++) cycle(0, en, 0, 0, 0, 0, 0);
  endtask

  initial begin
`ifdef COUNTER_SYNC_EN
    sync_avail = 1;
`else
    sync_avail = 0;
`endif
    m_sh_p = 0; m_sh_off = 0; m_sh_step = 0;

    // Reset values.
    cycle(1, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    check_eq("rst_sin_const", 32'(sin_counter_o), 32'd0);
    check_eq("rst_cos_const", 32'(cos_counter_o), 32'd10);

    // Free run across a wrap; SIN reaches 0 again after 40 enabled edges.
    run(39, 1);
    check_eq("t1_sin_39", 32'(sin_counter_o), 32'd39);
    cycle(0, 1, 0, 0, 0, 0, 0);
    check_eq("t1_wrap_pulse", 32'(phase_start_o), 32'd1);
    check_eq("t1_cos_after_wrap", 32'(cos_counter_o), 32'd10);
    run(5, 1);

    // Enable toggling.
    for (int i = 0; i < 80; i++) cycle(0, (i % 2) == 0, 0, 0, 0, 0, 0);

    // Mid-period reconfiguration P=15, off=4, step=3.
    run(3, 1);
    cycle(0, 1, 1, 15, 4, 3, 0);
    check_eq("t3_ready_low", 32'(cfg_ready_o), 32'd0);
    for (int i = 0; i < 60 && m_full; i++) cycle(0, 1, 0, 0, 0, 0, 0);
    check_eq("t3_sin_applied", 32'(sin_counter_o), 32'd0);
    check_eq("t3_cos_applied", 32'(cos_counter_o), 32'd4);
    cycle(0, 1, 0, 0, 0, 0, 0);
    check_eq("t3_sin_step3", 32'(sin_counter_o), 32'd3);
    run(20, 1);

    // Rejected configs: zero step, then offset beyond period.
    cycle(0, 1, 1, 15, 4, 0, 0);
    check_eq("t4_err_step0", 32'(cfg_err_o), 32'd1);
    cycle(0, 1, 1, 15, 20, 1, 0);
    check_eq("t4_err_off", 32'(cfg_err_o), 32'd1);
    run(4, 1);

    // Reset with a pending shadow.
    cycle(0, 1, 1, 30, 7, 2, 0);
    cycle(1, 1, 0, 0, 0, 0, 0);
    check_eq("t5_ready", 32'(cfg_ready_o), 32'd1);
    run(42, 1);

    // Realign at SIN=17 while halted.
    if (sync_avail) begin
      for (int i = 0; i < 50 && m_sin != 17; i++) cycle(0, 1, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 1);
      check_eq("t6_sync_sin", 32'(sin_counter_o), 32'd0);
      check_eq("t6_sync_cos", 32'(cos_counter_o), 32'd10);
      check_eq("t6_sync_pulse", 32'(phase_start_o), 32'd1);
      run(2, 0);
    end

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      int per, off, stp;
      bit rst, en, valid, sync;
      per   = $urandom_range(1, 80);
      stp   = $urandom_range(0, per + 1);
      off   = $urandom_range(0, per + 2);
      rst   = ($urandom_range(0, 199) == 0);
      en    = ($urandom_range(0, 3) != 0);
      valid = ($urandom_range(0, 7) == 0);
      sync  = sync_avail && ($urandom_range(0, 49) == 0);
      cycle(rst, en, valid, per, off, stp, sync);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
